regfile_2r1w: RTL
=================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised register file: NUM_REGS entries of WIDTH bits, one write port, two read ports.
//   Read data is registered, with same-cycle write-to-read bypass.
//   Out-of-range selects raise a sticky error flag.
//   Sits in the decode stage and feeds the ALU operand registers.
//   Reset clears all storage, so no X-masking is needed on the read path.
// PARAMETERS
//   WIDTH     16  data width of each register, in bits
//   NUM_REGS   8  number of entries; need not be a power of two
//   SEL_W      3  select width; must satisfy 2**SEL_W >= NUM_REGS
//   BYPASS     1  1 = a read sees the same-cycle write data; 0 = a read sees the pre-write value
// PORTS
//   clk       in   1      clock; all state updates on the rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   wr_en     in   1      write strobe
//   wr_sel    in   SEL_W  write index
//   wr_data   in   WIDTH  write data
//   rd_en     in   1      read strobe; samples both read selects
//   rd0_sel   in   SEL_W  read port 0 index
//   rd1_sel   in   SEL_W  read port 1 index
//   rd0_data  out  WIDTH  read port 0 data, registered
//   rd1_data  out  WIDTH  read port 1 data, registered
//   rd_valid  out  1      high in the cycle after an accepted rd_en
//   err       out  1      sticky flag: an out-of-range index was used
//   err_clr   in   1      synchronous clear of err
// BEHAVIOUR
//   Reset (rst_n low, asynchronous):
//     - all entries = 0; rd0_data = rd1_data = 0; rd_valid = 0; err = 0.
//     - Applies immediately, including mid-operation; any in-flight read is discarded.
//   Write:
//     - On an edge with wr_en=1 and wr_sel < NUM_REGS: mem[wr_sel] <= wr_data.
//     - New value is visible to a plain read one cycle later.
//   Read:
//     - On an edge with rd_en=1: rdN_data <= mem[rdNN_sel] for each port; rd_valid <= 1.
//     - Latency is 1 cycle.
//     - With rd_en=0: rdN_data holds its previous value; rd_valid <= 0.
//   Bypass (BYPASS=1):
//     - Applies when wr_en=1, rd_en=1 and rdN_sel == wr_sel < NUM_REGS.
//     - rdN_data <= wr_data.
//     - Both ports may bypass in the same cycle.
//   BYPASS=0: the same case returns the old mem value.
//   Out of range (index >= NUM_REGS):
//     - Read port with an out-of-range index: its data <= 0; err <= 1.
//     - Write with an out-of-range wr_sel: storage is unchanged; err <= 1.
//     - err is raised only when the corresponding strobe is high.
//   err:
//     - Cleared only by reset, or by err_clr=1 on an edge with no new error.
//     - A new error in the same cycle as err_clr wins, and err stays 1.
//   Simultaneous events:
//     - Both read ports may use the same index.
//     - A write and a read to different indices are independent.
//   No combinational path from any input to any output.
//   Every output is driven in every state; no latches; no X on outputs after reset.
// TESTING
//   T1 Reset:
//      - Stimulus: after rst_n deasserts, rd_en with rd0_sel=0 and rd1_sel=7.
//      - Response: next cycle rd0_data=0, rd1_data=0, rd_valid=1, err=0.
//   T2 Write then read:
//      - Stimulus: write 3<-16'hBEEF; next cycle rd_en with rd0_sel=3.
//      - Response: rd0_data=16'hBEEF one cycle later.
//   T3 Bypass:
//      - Stimulus: same cycle wr_en with 5<-16'h1234, rd_en with rd0_sel=5 and rd1_sel=5.
//      - Response: both ports = 16'h1234 (BYPASS=1); both ports = old value (BYPASS=0).
//   T4 Out of range:
//      - Stimulus: NUM_REGS=6; write 6<-16'hFFFF; rd_en with rd0_sel=7.
//      - Response: rd0_data=0; err=1; entries 0..5 unchanged.
//   T5 err sticky:
//      - Stimulus: err_clr alone; then err_clr in the same cycle as a new out-of-range read.
//      - Response: err=0 after the first; err stays 1 after the second.
//   T6 Mid-operation reset:
//      - Stimulus: pulse rst_n low between the rd_en edge and its result cycle.
//      - Response: immediately rd_valid=0, rd0_data=0, all entries 0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered reads,
// optional write-to-read bypass and a sticky out-of-range flag.
module regfile_2r1w #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd0_sel,
  input  logic [SEL_W-1:0] rd1_sel,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd_valid,
  output logic             err,
  input  logic             err_clr
);

  logic [WIDTH-1:0] mem [NUM_REGS];

  logic             wr_ok;
  logic             rd0_ok;
  logic             rd1_ok;
  logic             err_set;
  logic [WIDTH-1:0] rd0_nxt;
  logic [WIDTH-1:0] rd1_nxt;

  assign wr_ok  = 32'(wr_sel)  < NUM_REGS;
  assign rd0_ok = 32'(rd0_sel) < NUM_REGS;
  assign rd1_ok = 32'(rd1_sel) < NUM_REGS;

  assign err_set = (wr_en & ~wr_ok)
                 | (rd_en & ~(rd0_ok & rd1_ok));

  // out-of-range selects match no entry and read as zero
  always_comb begin
    rd0_nxt = '0;
    rd1_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd0_sel == SEL_W'(i)) rd0_nxt = mem[i];
      if (rd1_sel == SEL_W'(i)) rd1_nxt = mem[i];
    end
    if (BYPASS != 0 && wr_en && wr_ok) begin
      if (rd0_sel == wr_sel) rd0_nxt = wr_data;
      if (rd1_sel == wr_sel) rd1_nxt = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel == SEL_W'(i)) mem[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_data <= '0;
      rd1_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd0_data <= rd0_nxt;
        rd1_data <= rd1_nxt;
      end
    end
  end

  // a fresh error outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule
